// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky errors and registered or FWFT read.
// Write-to-readable latency is one cycle; a write while full or a read while empty is dropped and sets its error flag.
module sync_fifo_param #(
   parameter int DEPTH    = 16,
   parameter int D_WIDTH  = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [D_WIDTH-1:0] wr_data,
   input  logic               rd_en,
   output logic [D_WIDTH-1:0] rd_data,
   output logic               rd_valid,
   output logic               full_o,
   output logic               empty_o,
   output logic               almost_full_o,
   output logic               almost_empty_o,
   output logic [AW:0]        count_o,
   output logic               overflow_o,
   output logic               underflow_o,
   input  logic               clr_err
);

   localparam logic [AW:0] ONE     = (AW+1)'(1);
   localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_TH   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_TH   = (AW+1)'(AE_LEVEL);

   logic [D_WIDTH-1:0] mem [DEPTH];

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q,  count_d;
   logic        full_q,   full_d;
   logic        empty_q,  empty_d;
   logic        af_q,     af_d;
   logic        ae_q,     ae_d;
   logic        ovf_q,    ovf_d;
   logic        udf_q,    udf_d;

   logic        wr_acc;
   logic        rd_acc;

   // Acceptance looks only at the registered flags, never at the other request.
   assign wr_acc = wr_en && !full_q;
   assign rd_acc = rd_en && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ONE;
      end
      if (wr_acc && !rd_acc) begin
         count_d = count_q + ONE;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - ONE;
      end
   end

   always_comb begin
      full_d  = (count_d == FULL_C);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AF_TH);
      ae_d    = (count_d <= AE_TH);
   end

   // A new error event wins over a coincident clear.
   always_comb begin
      ovf_d = clr_err ? 1'b0 : ovf_q;
      udf_d = clr_err ? 1'b0 : udf_q;
      if (wr_en && full_q) begin
         ovf_d = 1'b1;
      end
      if (rd_en && empty_q) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   if (FWFT == 1'b0) begin : g_reg_read
      logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
      logic               rd_valid_q;

      always_comb begin
         rd_data_d = rd_data_q;
         if (rd_acc) begin
            rd_data_d = mem[rd_ptr_q[AW-1:0]];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end else begin : g_fwft_read
      // Head word is shown directly; rd_en acknowledges and pops it.
      assign rd_data  = mem[rd_ptr_q[AW-1:0]];
      assign rd_valid = !empty_q;
   end

   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable read mode (registered or first-word-fall-through). It generalises the team's 8-deep, 4-bit-pointer FIFO to any power-of-two depth and any data width. It is the buffering stage for same-clock producer/consumer paths, where a clock-domain-crossing FIFO would only add synchroniser latency.

## Interface
- DEPTH, 16, number of entries; power of two, >= 4
- D_WIDTH, 8, data word width in bits
- AF_LEVEL, DEPTH-2, almost_full_o asserts when count >= AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 2, almost_empty_o asserts when count <= AE_LEVEL; range 0..DEPTH-1
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- AW is derived as clog2(DEPTH). It is not user-settable.

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- wr_data  in  D_WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  D_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word (see Operation)
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count >= AF_LEVEL
- almost_empty_o  out  1  count <= AE_LEVEL
- count_o  out  AW+1  occupancy, 0..DEPTH
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow_o and underflow_o

## Operation
- Write and read pointers are AW+1-bit binary counters. The memory address is the low AW bits of each pointer, so wrap-around is natural modulo 2^(AW+1).
- A write is accepted when wr_en && !full_o. The word is stored at the write pointer, and the write pointer increments.
- A read is accepted when rd_en && !empty_o. The read pointer increments.
- Acceptance is judged on the registered flags only. When the FIFO is full, a simultaneous wr_en and rd_en accepts the read and rejects the write. When the FIFO is empty, a simultaneous wr_en and rd_en accepts the write and rejects the read.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- full_o, empty_o, almost_full_o, almost_empty_o and count_o are registered and computed from the next-state count. Each therefore reflects the FIFO contents immediately after the edge. None is a combinational function of wr_en or rd_en.
- Registered read mode (FWFT=0):
  - rd_data is registered and loads mem[rd_ptr] on an accepted read.
  - rd_valid is 1 in the cycle after an accepted read, 0 otherwise.
  - rd_data holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally, and rd_valid = !empty_o.
  - rd_en pops the displayed word.
- Errors:
  - wr_en && full_o sets overflow_o. rd_en && empty_o sets underflow_o.
  - Both flags are sticky until clr_err or reset.
  - If clr_err coincides with a new error event, the flag ends the cycle set.
- Reset (synchronous, and it overrides all other inputs in the same cycle):
  - Both pointers and count_o go to 0.
  - empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
  - rd_valid=0, rd_data=0 when FWFT=0, overflow_o=0, underflow_o=0.
  - Memory contents are not cleared.
- Reset asserted mid-transfer discards all stored words. Any write or read presented in the reset cycle is ignored and raises no error.

## Timing
- Write-to-empty_o deassert: the first edge with an accepted write clears empty_o. Data is readable from the next cycle.
- FWFT=0 read latency: 1 cycle from the accepted rd_en edge to rd_data and rd_valid.
- FWFT=1 read latency: the head word appears on rd_data in the cycle after the write edge that makes the FIFO non-empty.
- Throughput: one write and one read per cycle, sustained, when the FIFO is neither full nor empty.
- Flag-to-count consistency: flags and count_o always change on the same edge.

## Test plan
- Fill after reset, DEPTH=16, writing 0x00..0x0F:
  - almost_full_o rises with count_o=14.
  - full_o rises on the 16th write.
  - A 17th write is dropped and sets overflow_o. count_o stays 16.
- Drain, FWFT=0:
  - The sixteen reads return 0x00..0x0F in order, each with rd_valid one cycle after rd_en.
  - empty_o rises after the 16th read.
  - A further rd_en sets underflow_o, and rd_data holds 0x0F.
- Simultaneous wr_en/rd_en at count 5 for 40 cycles: count_o stays 5, the pointers wrap past 31, and the data order is preserved.
- Simultaneous wr_en/rd_en at full: the read is accepted, count_o drops to 15, and overflow_o is set. At empty: the write is accepted, count_o becomes 1, and underflow_o is set.
- FWFT=1, a single write of 0xA5 to an empty FIFO:
  - rd_data=0xA5 and rd_valid=1 on the next cycle, with no rd_en.
  - rd_en pops it, after which empty_o=1.
- Reset at count 9 with overflow_o set: on the next cycle count_o=0, empty_o=1, almost_empty_o=1, errors are cleared, and rd_valid=0. A clr_err coinciding with overflow leaves overflow_o=1.
